// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: two bit-reversed FFT lanes in, one natural-order valid/ready stream out.
// Build option FFT_OUT_SHIFT_EN: each frame is emitted DC-centred (index N/2 first).
package fft_out_reorder_pkg;
    localparam int CP_WIDTH = 16;

    typedef struct packed {
        logic signed [CP_WIDTH-1:0] re;
        logic signed [CP_WIDTH-1:0] im;
    } complex_product_t;
endpackage

module fft_out_reorder
    import fft_out_reorder_pkg::*;
#(
    parameter int DATA_WIDTH = CP_WIDTH,
    parameter int N          = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  complex_product_t     x0,
    input  complex_product_t     x1,
    input  logic                 in_valid,
    output logic                 in_ready,
    output complex_product_t     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [$clog2(N)-1:0] out_index,
    output logic [3:0]           bank_state_dbg
);
    localparam int LG = $clog2(N);

    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_FILLING  = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;
    localparam logic [1:0] ST_DRAINING = 2'd3;

    localparam logic [LG-2:0] WR_LAST = (LG-1)'(N / 2 - 1);
    localparam logic [LG-1:0] RD_LAST = LG'(N - 1);

    // Handshake: a beat moves on a rising edge where valid && ready. Valid never depends on
    // ready, and y/out_index/out_last/out_valid hold while out_valid && !out_ready.

    logic [2*DATA_WIDTH-1:0] mem [2][N];
    logic [1:0]              bank_state [2];
    logic                    wr_bank;
    logic                    rd_bank;
    logic                    init_done;
    logic [LG-2:0]           wr_cnt;
    logic [LG-1:0]           rd_cnt;

    logic                    wr_fire;
    logic                    wr_done;
    logic                    rd_fire;
    logic                    frame_done;
    logic                    ld_en;
    logic                    ld_bank;
    logic [LG-1:0]           ld_cnt;
    logic [LG-1:0]           ld_addr;

    function automatic logic [LG-1:0] bitrev(input logic [LG-1:0] a);
        logic [LG-1:0] r;
        for (int i = 0; i < LG; i++) begin
            r[i] = a[LG-1-i];
        end
        return r;
    endfunction

    assign bank_state_dbg = {bank_state[1], bank_state[0]};

    assign in_ready   = init_done &&
                        (bank_state[wr_bank] == ST_EMPTY || bank_state[wr_bank] == ST_FILLING);
    assign wr_fire    = in_valid && in_ready;
    assign wr_done    = wr_fire && (wr_cnt == WR_LAST);
    assign rd_fire    = out_valid && out_ready;
    assign frame_done = rd_fire && (rd_cnt == RD_LAST);

    // Pick the sample that the output register takes on this edge, if any.
    always_comb begin
        ld_en   = 1'b0;
        ld_bank = rd_bank;
        ld_cnt  = rd_cnt;
        if (rd_fire) begin
            if (frame_done) begin
                ld_bank = ~rd_bank;
                ld_cnt  = '0;
                ld_en   = (bank_state[~rd_bank] == ST_FULL);
            end else begin
                ld_cnt = rd_cnt + 1'b1;
                ld_en  = 1'b1;
            end
        end else if (!out_valid) begin
            ld_en = (bank_state[rd_bank] == ST_FULL);
        end
    end

`ifdef FFT_OUT_SHIFT_EN
    // Adding N/2 modulo N is just an MSB flip.
    assign ld_addr = {~ld_cnt[LG-1], ld_cnt[LG-2:0]};
`else
    assign ld_addr = ld_cnt;
`endif

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][bitrev({wr_cnt, 1'b0})] <= x0;
            mem[wr_bank][bitrev({wr_cnt, 1'b1})] <= x1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_done     <= 1'b0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            bank_state[0] <= ST_EMPTY;
            bank_state[1] <= ST_EMPTY;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_index     <= '0;
            y             <= '0;
        end else begin
            init_done <= 1'b1;
            if (wr_fire) begin
                wr_cnt <= wr_done ? '0 : wr_cnt + 1'b1;
                if (wr_done) wr_bank <= ~wr_bank;
            end
            if (rd_fire) begin
                rd_cnt <= frame_done ? '0 : rd_cnt + 1'b1;
                if (frame_done) rd_bank <= ~rd_bank;
            end
            // Writer and reader never own the same bank, so both updates can land together.
            for (int b = 0; b < 2; b++) begin
                if (wr_fire && wr_bank == 1'(b)) begin
                    bank_state[b] <= wr_done ? ST_FULL : ST_FILLING;
                end else if (rd_fire && rd_bank == 1'(b)) begin
                    bank_state[b] <= frame_done ? ST_EMPTY : ST_DRAINING;
                end
            end
            if (ld_en) begin
                y         <= complex_product_t'(mem[ld_bank][ld_addr]);
                out_index <= ld_addr;
                out_last  <= (ld_cnt == RD_LAST);
                out_valid <= 1'b1;
            end else if (rd_fire) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder: expected frames are queued when the last input pair
// of a frame is accepted and compared as the DUT emits them.
`timescale 1ns/1ps
module tb_fft_out_reorder;
    import fft_out_reorder_pkg::*;

    localparam int N  = 32;
    localparam int LG = $clog2(N);
    localparam int W  = LG + 32;
`ifdef FFT_OUT_SHIFT_EN
    localparam int SHIFT = N / 2;
`else
    localparam int SHIFT = 0;
`endif
    localparam logic [LG-1:0] LAST_IDX = LG'((N - 1 + SHIFT) % N);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    complex_product_t x0, x1, y;
    logic             in_valid, in_ready, out_valid, out_ready, out_last;
    logic [LG-1:0]    out_index;
    logic [3:0]       bank_state_dbg;

    logic [W-1:0] exp_q[$];
    int           pend_base[$];
    int           pair_k, cyc, last_acc;
    int           n_checks, n_pass;

    fft_out_reorder #(.DATA_WIDTH(16), .N(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .x0            (x0),
        .x1            (x1),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .y             (y),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .out_index     (out_index),
        .bank_state_dbg(bank_state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x0 = '0;
        x1 = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        pend_base.delete();
        pair_k = 0;
    endtask

    // ---------------- model / driver tasks ----------------
    function automatic int bitrev(input int a);
        int r;
        r = 0;
        for (int i = 0; i < LG; i++) begin
            if ((a >> i) & 1) r = r | (1 << (LG - 1 - i));
        end
        return r;
    endfunction

    task automatic push_frame(input int base);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (k + SHIFT) % N;
            exp_q.push_back({LG'(idx), 16'(base + idx), 16'(-(base + idx))});
        end
    endtask

    task automatic drive_pair(input int base, input int k);
        int a0, a1;
        a0 = bitrev(2 * k);
        a1 = bitrev(2 * k + 1);
        x0.re = 16'(base + a0);
        x0.im = 16'(-(base + a0));
        x1.re = 16'(base + a1);
        x1.im = 16'(-(base + a1));
    endtask

    // Called at each negedge: presents the next pending pair; in_ready is stable until the edge.
    task automatic drive_inputs();
        if (pend_base.size() == 0) begin
            in_valid = 1'b0;
        end else begin
            drive_pair(pend_base[0], pair_k);
            in_valid = 1'b1;
            if (in_ready) begin
                pair_k++;
                last_acc = cyc;
                if (pair_k == N / 2) begin
                    push_frame(pend_base[0]);
                    void'(pend_base.pop_front());
                    pair_k = 0;
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x0 = '0;
        x1 = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0b want 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL rst_out_last: got %0b want 0", out_last); else n_pass++;
        n_checks++; if (y !== '0) $display("FAIL rst_y: got %0h want 0", y); else n_pass++;
        n_checks++; if (out_index !== '0) $display("FAIL rst_out_index: got %0d want 0", out_index); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %0b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_single_frame();
        int got, first_v, t;
        logic [W-1:0] e;
        logic exp_last;
        do_reset();
        pend_base.push_back(0);
        got = 0; first_v = -1; t = 0; cyc = 0; last_acc = -1;
        while (got < N && t < 200) begin
            @(negedge clk); cyc++; t++;
            drive_inputs();
            out_ready = 1'b1;
            if (out_valid && first_v < 0) first_v = cyc;
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sf_extra: got idx=%0d re=%0h want no output", out_index, y.re);
                end else begin
                    e = exp_q.pop_front();
                    exp_last = (e[W-1:32] == LAST_IDX);
                    if ({out_index, y} !== e || out_last !== exp_last)
                        $display("FAIL sf_data: got idx=%0d y=%0h last=%0b want idx=%0d y=%0h last=%0b",
                                 out_index, y, out_last, e[W-1:32], e[31:0], exp_last);
                    else n_pass++;
                end
                got++;
            end
        end
        n_checks++; if (got != N) $display("FAIL sf_count: got %0d want %0d", got, N); else n_pass++;
        n_checks++; if (first_v != last_acc + 2) $display("FAIL sf_latency: got first valid at %0d want %0d", first_v, last_acc + 2); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL sf_leftover: got %0d want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int got, t, gaps, early_block;
        bit saw_block;
        logic [W-1:0] e;
        logic exp_last;
        do_reset();
        pend_base.push_back(200);
        pend_base.push_back(300);
        pend_base.push_back(400);
        got = 0; t = 0; gaps = 0; early_block = 0; saw_block = 0; cyc = 0;
        while (got < 3 * N && t < 400) begin
            @(negedge clk); cyc++; t++;
            drive_inputs();
            if (in_valid && !in_ready) begin
                if (pend_base.size() == 1 && pair_k == 0) saw_block = 1;
                else early_block++;
            end
            out_ready = 1'b1;
            if (got > 0 && !out_valid) gaps++;
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_extra: got idx=%0d re=%0h want no output", out_index, y.re);
                end else begin
                    e = exp_q.pop_front();
                    exp_last = (e[W-1:32] == LAST_IDX);
                    if ({out_index, y} !== e || out_last !== exp_last)
                        $display("FAIL b2b_data: got idx=%0d y=%0h last=%0b want idx=%0d y=%0h last=%0b",
                                 out_index, y, out_last, e[W-1:32], e[31:0], exp_last);
                    else n_pass++;
                end
                got++;
            end
        end
        n_checks++; if (got != 3 * N) $display("FAIL b2b_count: got %0d want %0d", got, 3 * N); else n_pass++;
        n_checks++; if (gaps != 0) $display("FAIL b2b_gaps: got %0d want 0", gaps); else n_pass++;
        n_checks++; if (!saw_block) $display("FAIL b2b_block: got no in_ready stall want stall before frame 3"); else n_pass++;
        n_checks++; if (early_block != 0) $display("FAIL b2b_early_block: got %0d want 0", early_block); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_backpressure();
        int got, t, tc;
        bit active;
        logic [W-1:0] e;
        logic exp_last;
        do_reset();
        pend_base.push_back(500);
        got = 0; t = 0; tc = 0; active = 0; cyc = 0;
        while (tc < 2 * N && t < 300) begin
            @(negedge clk); cyc++; t++;
            drive_inputs();
            if (pend_base.size() == 0 && out_valid) active = 1;
            out_ready = active && (tc % 2 == 0);
            if (active) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    if (out_valid) $display("FAIL bp_extra: got idx=%0d re=%0h want no output", out_index, y.re);
                    else n_pass++;
                end else begin
                    e = exp_q[0];
                    exp_last = (e[W-1:32] == LAST_IDX);
                    if (!out_valid || {out_index, y} !== e || out_last !== exp_last)
                        $display("FAIL bp_hold: got v=%0b idx=%0d y=%0h last=%0b want v=1 idx=%0d y=%0h last=%0b",
                                 out_valid, out_index, y, out_last, e[W-1:32], e[31:0], exp_last);
                    else n_pass++;
                    if (out_valid && out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
                tc++;
            end
        end
        n_checks++; if (got != N) $display("FAIL bp_count: got %0d want %0d in %0d cycles", got, N, 2 * N); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL bp_leftover: got %0d want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_mid_reset();
        int got, t;
        logic [W-1:0] e;
        logic exp_last;
        do_reset();
        pend_base.push_back(900);
        t = 0; cyc = 0;
        while (pair_k < 7 && t < 50) begin
            @(negedge clk); cyc++; t++;
            drive_inputs();
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mr_valid_in_reset: got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL mr_ready_in_reset: got %0b want 0", in_ready); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        pend_base.delete();
        pair_k = 0;
        exp_q.delete();
        pend_base.push_back(100);
        got = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk); cyc++;
            drive_inputs();
            out_ready = 1'b1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL mr_extra: got idx=%0d re=%0h want no output", out_index, y.re);
                end else begin
                    e = exp_q.pop_front();
                    exp_last = (e[W-1:32] == LAST_IDX);
                    if ({out_index, y} !== e || out_last !== exp_last)
                        $display("FAIL mr_data: got idx=%0d y=%0h last=%0b want idx=%0d y=%0h last=%0b",
                                 out_index, y, out_last, e[W-1:32], e[31:0], exp_last);
                    else n_pass++;
                end
                got++;
            end
        end
        n_checks++; if (got != N) $display("FAIL mr_count: got %0d want %0d", got, N); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL mr_leftover: got %0d want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_blocked_input();
        int got, t, markers;
        logic [W-1:0] e;
        logic exp_last;
        do_reset();
        pend_base.push_back(600);
        pend_base.push_back(700);
        t = 0; cyc = 0;
        out_ready = 1'b0;
        while (pend_base.size() != 0 && t < 100) begin
            @(negedge clk); cyc++; t++;
            drive_inputs();
        end
        n_checks++; if (pend_base.size() != 0) $display("FAIL blk_fill: got %0d frames unsent want 0", pend_base.size()); else n_pass++;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); cyc++;
            x0 = {16'hDEAD, 16'hDEAD};
            x1 = {16'hDEAD, 16'hDEAD};
            in_valid = 1'b1;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL blk_ready: got %0b want 0", in_ready); else n_pass++;
        end
        got = 0; markers = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk); cyc++;
            in_valid = 1'b0;
            out_ready = 1'b1;
            if (out_valid && out_ready) begin
                if (y.re == 16'hDEAD) markers++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL blk_extra: got idx=%0d re=%0h want no output", out_index, y.re);
                end else begin
                    e = exp_q.pop_front();
                    exp_last = (e[W-1:32] == LAST_IDX);
                    if ({out_index, y} !== e || out_last !== exp_last)
                        $display("FAIL blk_data: got idx=%0d y=%0h last=%0b want idx=%0d y=%0h last=%0b",
                                 out_index, y, out_last, e[W-1:32], e[31:0], exp_last);
                    else n_pass++;
                end
                got++;
            end
        end
        n_checks++; if (markers != 0) $display("FAIL blk_marker: got %0d marker outputs want 0", markers); else n_pass++;
        n_checks++; if (got != 2 * N) $display("FAIL blk_count: got %0d want %0d", got, 2 * N); else n_pass++;
        n_checks++; if (exp_q.size() != 0) $display("FAIL blk_leftover: got %0d want 0", exp_q.size()); else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks  = 0;
        n_pass    = 0;
        pair_k    = 0;
        cyc       = 0;
        last_acc  = -1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x0 = '0;
        x1 = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_blocked_input();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
